echo_engine: RTL and testbench
==============================

// Module: echo_engine
// PURPOSE
//  Parametrised sample-processing engine between spi2adc and spi2dac/pwm.
//  Generates the sampling tick and stores samples in a circular RAM buffer.
//  Produces one output sample per accepted input in one of four modes:
//  bypass, pure delay, FIR echo, feedback (IIR) echo.
//  Replaces the fixed-function processor stage in the ADC->DAC audio path.
// PARAMETERS
//  DW       10    sample width, offset-binary at ports (ADC/DAC code)
//  AW       13    buffer address width; depth 2**AW samples (0.82 s @10 kHz)
//  CLK_DIV  5000  sysclk cycles per sample_tick (50 MHz -> 10 kHz)
// PORTS
//  sysclk      in   1     system clock (50 MHz)
//  rst_n       in   1     asynchronous active-low reset
//  en          in   1     enable: tick generation and sample acceptance
//  mode        in   2     00 bypass, 01 delay, 10 FIR echo, 11 IIR echo
//  delay_len   in   AW    delay in samples (0..2**AW-1)
//  atten       in   3     echo gain = 2**-atten (arithmetic right shift)
//  sample_tick out  1     1-cycle pulse every CLK_DIV cycles; drives ADC start
//  adc_data    in   DW    sample from ADC (offset binary, mid = 2**(DW-1))
//  adc_valid   in   1     1-cycle strobe: adc_data valid
//  dac_data    out  DW    processed sample (offset binary)
//  dac_valid   out  1     1-cycle strobe: dac_data updated
//  busy        out  1     high while FSM not in IDLE
//  overrun     out  1     sticky: adc_valid arrived while busy
// BEHAVIOUR
//  Reset (async): sample_tick=0, dac_data=2**(DW-1), dac_valid=0, busy=0,
//   overrun=0; tick counter, wr_ptr and fill counter = 0; RAM not cleared.
//  Tick: counter 0..CLK_DIV-1, pulse when count==CLK_DIV-1, then wraps to 0.
//   en=0 holds counter at 0, no pulses; overrun cleared while en=0.
//  Accept: in IDLE with en=1 and adc_valid=1: latch x = adc_data - 2**(DW-1)
//   (signed, DW bits), plus mode, delay_len, atten. Later input changes
//   do not affect the in-flight sample.
//   adc_valid while busy: sample dropped, overrun<=1.
//   adc_valid with en=0: ignored; an in-flight sample still completes.
//  FSM: IDLE -> RD (raddr = wr_ptr - delay_len mod 2**AW) -> RDW
//   (1-cycle sync RAM latency) -> CALC -> WR -> IDLE.
//   busy is high in RD..WR (4 cycles).
//   In WR: write w to RAM[wr_ptr], wr_ptr++ (wraps mod 2**AW),
//   fill++ (saturates at 2**AW-1).
//   dac_data/dac_valid registered on WR exit: dac_valid pulses exactly 4
//   cycles after the adc_valid cycle. Back-to-back accept is allowed the
//   cycle after WR.
//  Delayed word d: RAM read (signed). Forced to 0 if delay_len==0 or
//   fill < delay_len, so unwritten RAM is never heard.
//  Arithmetic: e = d >>> atten. s = x + e, computed in DW+1 bits,
//   saturated to [-2**(DW-1), 2**(DW-1)-1].
//   00: y=x,   w=x      01: y=d,   w=x
//   10: y=sat(s), w=x   11: y=sat(s), w=y (feedback of saturated output)
//   dac_data = y + 2**(DW-1) (MSB inverted).
//  Reset mid-operation: FSM aborts to IDLE and no dac_valid is issued for
//   the aborted sample.
// TESTING
//  1 en=1, CLK_DIV=5000 -> sample_tick at cycles 4999, 9999, ...;
//    en=0 -> no pulses.
//  2 mode=00, adc_data=700 -> dac_data=700, dac_valid 4 cycles after
//    adc_valid, busy high 4 cycles.
//  3 mode=01, delay_len=3, inputs 600,610,620,630,640
//    -> outputs 512,512,512,600,610.
//  4 mode=10, atten=1, delay_len=1, inputs 712,712 -> outputs 712,812.
//  5 mode=11, atten=0, delay_len=1, inputs 1000 x3 -> outputs 1000,1023,1023.
//    adc_valid during busy -> overrun=1, dac_valid count unchanged.
//  6 rst_n low in CALC -> no dac_valid, dac_data=512. Then mode=01,
//    delay_len=1, one input 800 -> output 512 (fill counter cleared).

Source files
------------

// File: rtl/echo_engine.sv
// rtl/echo_engine.sv - sample tick, circular delay buffer and bypass/delay/FIR/IIR echo
//
// Ports
//   sysclk       system clock
//   rst_n        asynchronous active-low reset
//   en           enables tick generation and sample acceptance
//   mode         00 bypass, 01 delay, 10 FIR echo, 11 IIR echo
//   delay_len    echo delay in samples
//   atten        echo gain 2**-atten
//   sample_tick  one-cycle pulse every CLK_DIV cycles (ADC start)
//   adc_data     input sample, offset binary
//   adc_valid    one-cycle strobe for adc_data
//   dac_data     output sample, offset binary
//   dac_valid    one-cycle strobe for dac_data
//   busy         high while a sample is in flight
//   overrun      sticky: a sample arrived while busy (cleared by en=0)
module echo_engine #(
   parameter int DW      = 10,
   parameter int AW      = 13,
   parameter int CLK_DIV = 5000
) (
   input  logic          sysclk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] delay_len,
   input  logic [2:0]    atten,
   output logic          sample_tick,
   input  logic [DW-1:0] adc_data,
   input  logic          adc_valid,
   output logic [DW-1:0] dac_data,
   output logic          dac_valid,
   output logic          busy,
   output logic          overrun
);

   localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
   localparam logic [DW-1:0] MID       = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] SMAX      = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] SMIN      = {1'b1, {(DW-1){1'b0}}};
   localparam logic [AW-1:0] FILL_MAX  = '1;

   typedef enum logic [2:0] {IDLE, RD, RDW, CALC, WR} state_t;

   state_t                state;
   logic [CW-1:0]         tick_cnt;
   logic [CW-1:0]         tick_nxt;
   logic signed [DW-1:0]  x_r;
   logic [1:0]            mode_r;
   logic [AW-1:0]         delay_r;
   logic [2:0]            atten_r;
   logic signed [DW-1:0]  y_r;
   logic signed [DW-1:0]  w_r;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         fill;
   logic [AW-1:0]         raddr;
   logic [DW-1:0]         rdata;
   logic [DW-1:0]         mem [2**AW];

   logic signed [DW-1:0]  d;
   logic signed [DW-1:0]  e;
   logic signed [DW:0]    s;
   logic signed [DW-1:0]  s_sat;
   logic signed [DW-1:0]  y_n;
   logic signed [DW-1:0]  w_n;

   // Tick: the pulse is registered so it coincides with tick_cnt == CLK_DIV-1.
   assign tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CW'(1);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt    <= '0;
         sample_tick <= 1'b0;
      end else if (!en) begin
         tick_cnt    <= '0;
         sample_tick <= 1'b0;
      end else begin
         tick_cnt    <= tick_nxt;
         sample_tick <= (tick_nxt == TICK_LAST);
      end
   end

   // Buffer: synchronous read, address is stable from RD through CALC.
   assign raddr = wr_ptr - delay_r;

   always_ff @(posedge sysclk) begin
      if (state == WR)
         mem[wr_ptr] <= w_r;
      rdata <= mem[raddr];
   end

   always_comb begin
      // Unwritten locations are never heard: mute until enough history exists.
      d = ((delay_r == '0) || (fill < delay_r)) ? '0 : $signed(rdata);
      e = d >>> atten_r;
      s = {x_r[DW-1], x_r} + {e[DW-1], e};
      if (s[DW] != s[DW-1])
         s_sat = s[DW] ? SMIN : SMAX;
      else
         s_sat = s[DW-1:0];
      y_n = x_r;
      w_n = x_r;
      case (mode_r)
         2'b00: y_n = x_r;
         2'b01: y_n = d;
         2'b10: y_n = s_sat;
         2'b11: begin
            y_n = s_sat;
            w_n = s_sat;
         end
         default: y_n = x_r;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         x_r       <= '0;
         mode_r    <= '0;
         delay_r   <= '0;
         atten_r   <= '0;
         y_r       <= '0;
         w_r       <= '0;
         wr_ptr    <= '0;
         fill      <= '0;
         dac_data  <= MID;
         dac_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         dac_valid <= 1'b0;

         if (!en)
            overrun <= 1'b0;
         else if (adc_valid && (state != IDLE))
            overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (en && adc_valid) begin
                  x_r     <= $signed(adc_data ^ MID);
                  mode_r  <= mode;
                  delay_r <= delay_len;
                  atten_r <= atten;
                  busy    <= 1'b1;
                  state   <= RD;
               end
            end
            RD:   state <= RDW;
            RDW:  state <= CALC;
            CALC: begin
               y_r   <= y_n;
               w_r   <= w_n;
               state <= WR;
            end
            WR: begin
               wr_ptr <= wr_ptr + AW'(1);
               if (fill != FILL_MAX)
                  fill <= fill + AW'(1);
               dac_data  <= y_r ^ MID;
               dac_valid <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_echo_engine.sv
// tb/tb_echo_engine.sv - directed self-checking bench for echo_engine
module tb_echo_engine;

   logic        sysclk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [12:0] delay_len = '0;
   logic [2:0]  atten = '0;
   logic        sample_tick;
   logic [9:0]  adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [9:0]  dac_data;
   logic        dac_valid;
   logic        busy;
   logic        overrun;

   int n_vec = 0;
   int n_err = 0;
   int dv_cnt = 0;

   echo_engine #(.DW(10), .AW(13), .CLK_DIV(5000)) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .en          (en),
      .mode        (mode),
      .delay_len   (delay_len),
      .atten       (atten),
      .sample_tick (sample_tick),
      .adc_data    (adc_data),
      .adc_valid   (adc_valid),
      .dac_data    (dac_data),
      .dac_valid   (dac_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #10 sysclk = ~sysclk;

   always @(posedge sysclk) begin
      #1;
      if (dac_valid === 1'b1) dv_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      rst_n = 1'b0;
      adc_valid = 1'b0;
      @(negedge sysclk);
      @(negedge sysclk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge; returns output sample, posedges from accept to
   // dac_valid, and number of sampled busy cycles.
   task automatic send(input logic [9:0] din, output logic [9:0] dout,
                       output int lat, output int bcnt);
      int k;
      adc_data  = din;
      adc_valid = 1'b1;
      @(posedge sysclk);
      @(negedge sysclk);
      adc_valid = 1'b0;
      k = 0;
      bcnt = (busy === 1'b1) ? 1 : 0;
      while ((dac_valid !== 1'b1) && (k < 20)) begin
         @(posedge sysclk);
         @(negedge sysclk);
         k++;
         if (busy === 1'b1) bcnt++;
      end
      lat  = (k < 20) ? k : 99;
      dout = (k < 20) ? dac_data : 10'h3ff;
   endtask

   initial begin
      int n_tick, first_t, second_t, lat, bcnt, snap;
      logic [9:0] dout;
      int t3_in[5]  = '{600, 610, 620, 630, 640};
      int t3_exp[5] = '{512, 512, 512, 600, 610};
      int t5_exp[3] = '{1000, 1023, 1023};

      do_reset();
      check("rst_dac_data", dac_data, 512);
      check("rst_dac_valid", dac_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_tick", sample_tick, 0);

      // Tick generation
      n_tick = 0;
      repeat (200) begin
         @(negedge sysclk);
         if (sample_tick === 1'b1) n_tick++;
      end
      check("tick_en0_none", n_tick, 0);
      en = 1'b1;
      n_tick = 0; first_t = 0; second_t = 0;
      for (int i = 1; i <= 10000; i++) begin
         @(posedge sysclk);
         #1;
         if (sample_tick === 1'b1) begin
            n_tick++;
            if (n_tick == 1) first_t = i;
            if (n_tick == 2) second_t = i;
         end
      end
      check("tick_count", n_tick, 2);
      check("tick_first", first_t, 4999);
      check("tick_second", second_t, 9999);

      // Bypass
      do_reset();
      en = 1'b1; mode = 2'b00;
      send(10'd700, dout, lat, bcnt);
      check("byp_data", dout, 700);
      check("byp_latency", lat, 4);
      check("byp_busy_cycles", bcnt, 4);
      @(negedge sysclk);
      check("byp_valid_1cyc", dac_valid, 0);

      // Pure delay
      do_reset();
      mode = 2'b01; delay_len = 13'd3;
      for (int i = 0; i < 5; i++) begin
         send(t3_in[i][9:0], dout, lat, bcnt);
         check($sformatf("dly_out%0d", i), dout, t3_exp[i]);
      end

      // FIR echo
      do_reset();
      mode = 2'b10; atten = 3'd1; delay_len = 13'd1;
      send(10'd712, dout, lat, bcnt);
      check("fir_out0", dout, 712);
      send(10'd712, dout, lat, bcnt);
      check("fir_out1", dout, 812);

      // IIR echo with saturation
      do_reset();
      mode = 2'b11; atten = 3'd0; delay_len = 13'd1;
      for (int i = 0; i < 3; i++) begin
         send(10'd1000, dout, lat, bcnt);
         check($sformatf("iir_out%0d", i), dout, t5_exp[i]);
      end

      // Overrun: second strobe while busy is dropped
      check("ovr_before", overrun, 0);
      snap = dv_cnt;
      adc_data = 10'd600; adc_valid = 1'b1;
      @(negedge sysclk);
      adc_valid = 1'b0;
      @(negedge sysclk);
      adc_valid = 1'b1;
      @(negedge sysclk);
      adc_valid = 1'b0;
      repeat (12) @(negedge sysclk);
      check("ovr_flag", overrun, 1);
      check("ovr_dv_count", dv_cnt - snap, 1);
      en = 1'b0;
      @(negedge sysclk);
      @(negedge sysclk);
      check("ovr_clear_en0", overrun, 0);

      // adc_valid ignored while disabled
      snap = dv_cnt;
      adc_valid = 1'b1;
      @(negedge sysclk);
      adc_valid = 1'b0;
      repeat (8) @(negedge sysclk);
      check("en0_ignored_dv", dv_cnt - snap, 0);
      check("en0_ignored_busy", busy, 0);

      // Reset while in CALC aborts the sample
      do_reset();
      en = 1'b1; mode = 2'b00;
      snap = dv_cnt;
      adc_data = 10'd900; adc_valid = 1'b1;
      @(posedge sysclk);
      @(negedge sysclk);
      adc_valid = 1'b0;
      @(posedge sysclk);
      @(posedge sysclk);
      @(negedge sysclk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_dac_data", dac_data, 512);
      repeat (3) @(negedge sysclk);
      rst_n = 1'b1;
      repeat (8) @(negedge sysclk);
      check("abort_no_valid", dv_cnt - snap, 0);
      check("abort_dac_hold", dac_data, 512);
      mode = 2'b01; delay_len = 13'd1;
      send(10'd800, dout, lat, bcnt);
      check("abort_fill_cleared", dout, 512);
      check("abort_latency", lat, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
